mod_reduce_unit: RTL and testbench
==================================

Name: mod_reduce_unit

Overview:
Downstream stage of the cipher-decode multiplier. It consumes the accumulated product `Prod` and the modulus, and reduces the product to `Prod mod modulus` with a bit-serial restoring divider. The run starts on the rising edge of the upstream `enDiv` flag. Its registered remainder is the recovered plaintext nibble; the quotient is exported for debug.

Parameters:
- DW, 8, dividend width; matches upstream Prod.
- MW, 4, modulus and remainder width; matches cipherText/privateKey nibble width.

Ports:
- CLK  input  1  system clock; all state updates on its rising edge.
- RST  input  1  asynchronous, active-high reset.
- enDiv  input  1  start flag from the multiplier stage; only its rising edge matters.
- Prod  input  DW  dividend; sampled on the start edge only.
- modulus  input  MW  divisor; sampled on the start edge only.
- plainText  output  MW  registered remainder.
- quotient  output  DW  registered quotient.
- busy  output  1  high from the capture edge until `done`.
- done  output  1  one-cycle pulse when results are valid.
- divErr  output  1  registered; set when the captured modulus is 0.

Behaviour:
- Reset (async, immediate):
  - plainText=0, quotient=0, busy=0, done=0, divErr=0, state=IDLE.
  - Edge-detect register enDiv_q resets to 1, so a level already high out of reset does not start a run.
- Start condition: state==IDLE, enDiv==1 and enDiv_q==0 at a clock edge (edge E0).
  - At E0: capture Prod and modulus, clear the partial remainder (MW+1 bits) and quotient shift register, busy<=1.
- State IDLE:
  - start with modulus==0 → DONE.
  - start otherwise → ITER, bit counter = DW-1.
- State ITER, one dividend bit per edge, MSB first:
  - r = {r[MW-1:0], Prod_reg[cnt]}.
  - If r >= {1'b0, modulus}: r -= modulus and shift 1 into the quotient; else shift 0.
  - At cnt==0 → DONE, else cnt-1.
- State DONE, one edge:
  - Register plainText = r[MW-1:0] and quotient, drive done=1 for the following cycle, busy<=0, → IDLE.
  - If divErr: plainText=0, quotient=all ones, divErr=1.
  - Otherwise divErr=0.
- Latency: normal runs pulse done after edge E(DW+1), i.e. 9 edges after E0 for DW=8. The modulus==0 path pulses done after E1.
- plainText, quotient and divErr hold their values until the next DONE or reset.
- enDiv_q updates every edge regardless of state.
- Start edges seen while busy are ignored and not queued.
- A start edge in the same cycle that done is high is accepted, because state is already IDLE.
- Reset asserted mid-run aborts the run and leaves no partial result. A start edge is required afterwards.
- The remainder is always < modulus, so it fits MW bits. The partial remainder needs MW+1 bits to avoid compare overflow.

Optional Feature:
MOD_REDUCE_EARLY_EXIT_EN
- Defined: at E0, if Prod < modulus (and modulus != 0), go straight to DONE with r=Prod and quotient=0. done pulses after E1.
- Undefined: every nonzero-modulus run takes the full DW iterations.
- Results are identical either way; only latency differs.

Decomposition:
- Package cipher_pkg holds:
  - constants CIPHER_DW=8 and CIPHER_MW=4, shared with the multiplier stage;
  - state typedef {IDLE, ITER, DONE};
  - the divErr quotient fill value.
- One natural sub-module: mod_sub_step. It is combinational and performs one compare-subtract; inputs r_in[MW:0], modulus; outputs r_out, qbit. It is instantiated once in the ITER datapath.

Test Plan:
1. Prod=200, modulus=7, enDiv 0→1 → plainText=4, quotient=28, divErr=0. done 9 edges after capture; busy high throughout.
2. Prod=255, modulus=15 → plainText=0, quotient=17. Second start 1 cycle after done with Prod=100, modulus=9 → plainText=1, quotient=11.
3. Prod=5, modulus=7 → plainText=5, quotient=0. done after 9 edges without the macro, after 1 edge with MOD_REDUCE_EARLY_EXIT_EN.
4. modulus=0, Prod=42 → divErr=1, plainText=0, quotient=255, done after 1 edge. The next valid run clears divErr.
5. enDiv toggles 0→1→0→1 at cycle 3 of a run → the second edge is ignored; a single done pulse with results for the first operands.
6. Two further reset cases:
   - RST pulsed at ITER cycle 4 → all outputs 0 immediately, busy=0.
   - enDiv held high through reset release → no start; a later 0→1 edge runs normally.

Source files
------------

// File: rtl/cipher_pkg.sv
//==============================================================================
// Module      : cipher_pkg
// Description : Shared constants and types for the cipher-decode datapath.
//               Holds the multiplier/reducer widths, the reducer FSM state
//               type and the quotient fill used when the modulus is zero.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package cipher_pkg;

    // Widths shared with the upstream multiplier stage.
    localparam int CIPHER_DW = 8;   // product / dividend width
    localparam int CIPHER_MW = 4;   // modulus / nibble width

    // Reducer control states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bit replicated across the whole quotient when a divide-by-zero is
    // reported, so the quotient reads as all ones at any width.
    localparam logic DIV_ERR_QUOT_FILL_BIT = 1'b1;

endpackage : cipher_pkg

`default_nettype wire

// File: rtl/mod_sub_step.sv
//==============================================================================
// Module      : mod_sub_step
// Description : One restoring-division step (combinational compare/subtract).
//   r_in    [MW:0]   shifted partial remainder (MW+1 bits so the compare
//                    against the modulus cannot overflow)
//   modulus [MW-1:0] divisor
//   r_out   [MW-1:0] remainder after the step; always < modulus, so MW bits
//                    are enough to hold it
//   qbit             quotient bit produced by this step
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mod_sub_step #(
    parameter int MW = 4
) (
    input  logic [MW:0]   r_in,
    input  logic [MW-1:0] modulus,
    output logic [MW-1:0] r_out,
    output logic          qbit
);

    always_comb begin
        qbit  = (r_in >= {1'b0, modulus});
        // After a subtraction the result is below the modulus, and when no
        // subtraction happens r_in was already below it; either way the top
        // bit is zero and can be dropped.
        r_out = qbit ? MW'(r_in - {1'b0, modulus}) : r_in[MW-1:0];
    end

endmodule : mod_sub_step

`default_nettype wire

// File: rtl/mod_reduce_unit.sv
//==============================================================================
// Module      : mod_reduce_unit
// Description : Reduces the upstream product to Prod mod modulus with a
//               bit-serial restoring divider started on the rising edge of
//               enDiv. The remainder is the recovered plaintext nibble; the
//               quotient is exported for debug.
// Ports       :
//   CLK        in   system clock (rising edge)
//   RST        in   asynchronous active-high reset
//   enDiv      in   start flag; only its rising edge starts a run
//   Prod       in   [DW-1:0] dividend, sampled on the start edge
//   modulus    in   [MW-1:0] divisor, sampled on the start edge
//   plainText  out  [MW-1:0] registered remainder
//   quotient   out  [DW-1:0] registered quotient
//   busy       out  high from the capture edge until done
//   done       out  one-cycle pulse when results are valid
//   divErr     out  registered; set when the captured modulus was zero
// Build option: MOD_REDUCE_EARLY_EXIT_EN
//   Defined   : a dividend already below the modulus skips the iterations.
//   Undefined : every nonzero-modulus run performs all DW iterations.
//   Results are identical; only latency differs.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mod_reduce_unit
    import cipher_pkg::*;
#(
    parameter int DW = CIPHER_DW,
    parameter int MW = CIPHER_MW
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          enDiv,
    input  logic [DW-1:0] Prod,
    input  logic [MW-1:0] modulus,
    output logic [MW-1:0] plainText,
    output logic [DW-1:0] quotient,
    output logic          busy,
    output logic          done,
    output logic          divErr
);

    localparam int CNT_W = (DW > 1) ? $clog2(DW) : 1;

    state_t            state_q,    state_d;
    logic              en_div_q,   en_div_d;
    logic [DW-1:0]     prod_q,     prod_d;
    logic [MW-1:0]     mod_q,      mod_d;
    logic [MW-1:0]     rem_q,      rem_d;
    logic [DW-1:0]     quo_q,      quo_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;
    logic              err_q,      err_d;
    logic [MW-1:0]     plain_q,    plain_d;
    logic [DW-1:0]     quot_q,     quot_d;
    logic              busy_q,     busy_d;
    logic              done_q,     done_d;
    logic              div_err_q,  div_err_d;

    logic              start;
    logic [MW:0]       step_in;
    logic [MW-1:0]     step_rem;
    logic              step_qbit;

    // Shift the next dividend bit (MSB first) into the partial remainder.
    assign step_in = {rem_q, prod_q[cnt_q]};

    mod_sub_step #(
        .MW (MW)
    ) u_sub_step (
        .r_in    (step_in),
        .modulus (mod_q),
        .r_out   (step_rem),
        .qbit    (step_qbit)
    );

    // Start edges seen while a run is in progress are dropped, not queued.
    assign start = (state_q == ST_IDLE) && enDiv && !en_div_q;

    always_comb begin
        state_d   = state_q;
        en_div_d  = enDiv;
        prod_d    = prod_q;
        mod_d     = mod_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        plain_d   = plain_q;
        quot_d    = quot_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        div_err_d = div_err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    prod_d = Prod;
                    mod_d  = modulus;
                    rem_d  = '0;
                    quo_d  = '0;
                    cnt_d  = CNT_W'(DW - 1);
                    busy_d = 1'b1;
                    err_d  = (modulus == '0);
                    if (modulus == '0) begin
                        state_d = ST_DONE;
`ifdef MOD_REDUCE_EARLY_EXIT_EN
                    end else if (Prod < DW'(modulus)) begin
                        // Dividend is already the remainder; quotient stays 0.
                        rem_d   = MW'(Prod);
                        state_d = ST_DONE;
`endif
                    end else begin
                        state_d = ST_ITER;
                    end
                end
            end

            ST_ITER: begin
                rem_d = step_rem;
                quo_d = {quo_q[DW-2:0], step_qbit};
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            ST_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
                if (err_q) begin
                    plain_d   = '0;
                    quot_d    = {DW{DIV_ERR_QUOT_FILL_BIT}};
                    div_err_d = 1'b1;
                end else begin
                    plain_d   = rem_q;
                    quot_d    = quo_q;
                    div_err_d = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            // Reset high so a level already asserted out of reset is not
            // mistaken for a rising edge.
            en_div_q  <= 1'b1;
            prod_q    <= '0;
            mod_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            plain_q   <= '0;
            quot_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            div_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            en_div_q  <= en_div_d;
            prod_q    <= prod_d;
            mod_q     <= mod_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            plain_q   <= plain_d;
            quot_q    <= quot_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            div_err_q <= div_err_d;
        end
    end

    assign plainText = plain_q;
    assign quotient  = quot_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign divErr    = div_err_q;

endmodule : mod_reduce_unit

`default_nettype wire

// File: tb/tb_mod_reduce_unit.sv
//==============================================================================
// Module      : tb_mod_reduce_unit
// Description : Self-checking bench for mod_reduce_unit. Directed vector
//               table, randomized runs against an arithmetic reference
//               model, and hand-written sequences for start-edge filtering
//               and reset behaviour.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mod_reduce_unit;

    localparam int DW = 8;
    localparam int MW = 4;

    logic          clk;
    logic          rst;
    logic          en_div;
    logic [DW-1:0] prod;
    logic [MW-1:0] modulus;
    logic [MW-1:0] plain_text;
    logic [DW-1:0] quotient;
    logic          busy;
    logic          done;
    logic          div_err;

    int errors = 0;
    int checks = 0;

    mod_reduce_unit #(
        .DW (DW),
        .MW (MW)
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .enDiv     (en_div),
        .Prod      (prod),
        .modulus   (modulus),
        .plainText (plain_text),
        .quotient  (quotient),
        .busy      (busy),
        .done      (done),
        .divErr    (div_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] p;
        logic [MW-1:0] m;
        logic [MW-1:0] exp_rem;
        logic [DW-1:0] exp_quo;
        logic          exp_err;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference latency in edges from the capture edge to the done pulse.
    function automatic int exp_latency(input int p, input int m);
        if (m == 0) return 1;
`ifdef MOD_REDUCE_EARLY_EXIT_EN
        if (p < m) return 1;
`endif
        return DW + 1;
    endfunction

    // One complete run: start edge, operand scrambling after capture,
    // latency / busy / result checks.
    task automatic run_op(input string tag, input int p, input int m,
                          input int e_rem, input int e_quo, input int e_err);
        int  lat;
        int  n;
        bit  seen;
        bit  busy_ok;
        lat = exp_latency(p, m);
        @(negedge clk);
        prod    = DW'(p);
        modulus = MW'(m);
        en_div  = 1'b1;
        @(posedge clk);
        #1;
        check({tag, " busy@E0"}, int'(busy), 1);
        check({tag, " done@E0"}, int'(done), 0);
        @(negedge clk);
        en_div  = 1'b0;
        prod    = DW'($urandom);
        modulus = MW'($urandom);
        n       = 0;
        seen    = 1'b0;
        busy_ok = 1'b1;
        while (!seen && n < 20) begin
            @(posedge clk);
            n++;
            #1;
            if (done) seen = 1'b1;
            else if (!busy) busy_ok = 1'b0;
        end
        check({tag, " done_seen"}, int'(seen), 1);
        check({tag, " latency"}, n, lat);
        check({tag, " busy_held"}, int'(busy_ok), 1);
        check({tag, " busy@done"}, int'(busy), 0);
        check({tag, " plainText"}, int'(plain_text), e_rem);
        check({tag, " quotient"}, int'(quotient), e_quo);
        check({tag, " divErr"}, int'(div_err), e_err);
    endtask

    initial begin
        vec_t vecs[9];
        int   ndone;
        int   first_done;

        vecs[0] = '{p: 8'd200, m: 4'd7,  exp_rem: 4'd4,  exp_quo: 8'd28,  exp_err: 1'b0};
        vecs[1] = '{p: 8'd255, m: 4'd15, exp_rem: 4'd0,  exp_quo: 8'd17,  exp_err: 1'b0};
        vecs[2] = '{p: 8'd100, m: 4'd9,  exp_rem: 4'd1,  exp_quo: 8'd11,  exp_err: 1'b0};
        vecs[3] = '{p: 8'd5,   m: 4'd7,  exp_rem: 4'd5,  exp_quo: 8'd0,   exp_err: 1'b0};
        vecs[4] = '{p: 8'd42,  m: 4'd0,  exp_rem: 4'd0,  exp_quo: 8'd255, exp_err: 1'b1};
        vecs[5] = '{p: 8'd255, m: 4'd1,  exp_rem: 4'd0,  exp_quo: 8'd255, exp_err: 1'b0};
        vecs[6] = '{p: 8'd0,   m: 4'd3,  exp_rem: 4'd0,  exp_quo: 8'd0,   exp_err: 1'b0};
        vecs[7] = '{p: 8'd15,  m: 4'd15, exp_rem: 4'd0,  exp_quo: 8'd1,   exp_err: 1'b0};
        vecs[8] = '{p: 8'd200, m: 4'd7,  exp_rem: 4'd4,  exp_quo: 8'd28,  exp_err: 1'b0};

        rst     = 1'b1;
        en_div  = 1'b0;
        prod    = '0;
        modulus = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset plainText", int'(plain_text), 0);
        check("reset quotient", int'(quotient), 0);
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset divErr", int'(div_err), 0);
        @(posedge clk);

        // Back-to-back table runs: each new start lands in the done cycle
        // of the previous run. Vector 5 follows the divide-by-zero run and
        // must clear divErr.
        for (int i = 0; i < 9; i++) begin
            run_op($sformatf("vec%0d", i), int'(vecs[i].p), int'(vecs[i].m),
                   int'(vecs[i].exp_rem), int'(vecs[i].exp_quo),
                   int'(vecs[i].exp_err));
        end

        // Randomized runs against plain division.
        for (int i = 0; i < 30; i++) begin
            int p;
            int m;
            p = int'($urandom_range(0, 255));
            m = int'($urandom_range(0, 15));
            if (m == 0) run_op($sformatf("rnd%0d", i), p, m, 0, 255, 1);
            else        run_op($sformatf("rnd%0d", i), p, m, p % m, p / m, 0);
        end

        // Second rising edge mid-run is ignored; one done with first results.
        @(negedge clk);
        prod    = 8'd200;
        modulus = 4'd7;
        en_div  = 1'b1;
        @(negedge clk);
        en_div  = 1'b0;
        prod    = 8'd17;
        modulus = 4'd3;
        @(negedge clk);
        en_div  = 1'b1;
        @(negedge clk);
        en_div  = 1'b0;
        ndone      = 0;
        first_done = 0;
        for (int e = 3; e <= 20; e++) begin
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                if (first_done == 0) first_done = e;
            end
        end
        check("retrig done_count", ndone, 1);
        check("retrig done_edge", first_done, DW + 1);
        check("retrig plainText", int'(plain_text), 4);
        check("retrig quotient", int'(quotient), 28);

        // Reset mid-run clears outputs immediately and leaves no result.
        run_op("pre_rst", 100, 9, 1, 11, 0);
        @(negedge clk);
        prod    = 8'd250;
        modulus = 4'd6;
        en_div  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        en_div = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst plainText", int'(plain_text), 0);
        check("midrst quotient", int'(quotient), 0);
        check("midrst busy", int'(busy), 0);
        check("midrst divErr", int'(div_err), 0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int e = 0; e < 12; e++) begin
            @(posedge clk);
            #1;
            if (done || busy) ndone++;
        end
        check("midrst no_activity", ndone, 0);

        // enDiv held high through reset release must not start a run.
        @(negedge clk);
        en_div  = 1'b1;
        prod    = 8'd77;
        modulus = 4'd5;
        rst     = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int e = 0; e < 12; e++) begin
            @(posedge clk);
            #1;
            if (done || busy) ndone++;
        end
        check("hi_thru_rst no_start", ndone, 0);
        @(negedge clk);
        en_div = 1'b0;
        run_op("post_rst", 77, 5, 2, 15, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mod_reduce_unit

`default_nettype wire
